mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
//
// PURPOSE
// - Round-robin arbiter sharing one memory/bus port among 4 requesters
//   (e.g. IF, MEM, DMA, debug). Drives the 2-bit select of the 4:1 datapath
//   mux in front of the shared port, plus one-hot grants back to requesters.
// - Grant is held for a whole transaction until the port signals Done,
//   so the mux select never changes mid-transfer.
//
// PARAMETERS
// - TIMEOUT_CYCLES  default 64  max cycles a grant may be held without Done
//                               (used only when ARB_TIMEOUT_EN is defined; must be >= 2)
// - CNT_W           default 7   width of hold-cycle counter; 2**CNT_W > TIMEOUT_CYCLES
//
// PORTS
// - clk        in   1  single clock, all logic on rising edge
// - rst        in   1  synchronous, active-high reset
// - Req        in   4  Req[i]=1: requester i wants the port; level, held until served
// - Done       in   1  shared port finished current transaction (valid only while Busy)
// - Grant      out  4  one-hot grant, registered; all-zero when idle
// - Sel        out  2  mux select = index of granted requester; holds last value when idle
// - Busy       out  1  1 while a grant is active (Grant != 0)
// - TimeoutErr out  1  one-cycle pulse when a grant is revoked by the watchdog
//
// BEHAVIOUR
// - Reset (rst=1 at clk edge): Grant=0, Sel=2'b00, Busy=0, TimeoutErr=0,
//   priority pointer Ptr=0, hold counter=0, state=IDLE. Reset overrides all;
//   asserting rst mid-transaction drops the grant on that edge.
// - States: IDLE (no grant), GRANT (one requester owns port).
// - Arbitration: winner = first i with Req[i]=1 scanning Ptr, Ptr+1, ... mod 4.
// - IDLE: if Req!=0, next edge -> GRANT, Grant=onehot(winner), Sel=winner,
//   Busy=1 (1-cycle latency Req->Grant). If Req==0 stay IDLE, Sel unchanged.
// - GRANT, owner k, release events evaluated each cycle:
//   a) Done=1; b) Req[k]=0 (requester abandoned); c) watchdog expiry.
//   Any event: Ptr <= (k+1) mod 4; re-arbitrate same cycle using the new Ptr
//   over current Req with Req[k] masked off; if a winner w exists, next edge
//   Grant=onehot(w), Sel=w (back-to-back, no bubble); else -> IDLE, Grant=0.
//   Requester k may win again only on a later arbitration (no self-regrant).
// - No event: Grant, Sel, Ptr held; Req changes of non-owners ignored.
// - Done while IDLE is ignored. Done and Req[k]=0 same cycle = one release.
// - Ptr wraps 3 -> 0. With all 4 requesting continuously and Done every
//   cycle, grant order is 0,1,2,3,0,... ; max wait for any requester = 3 grants.
// - Hold counter: cleared on each new grant, +1 per cycle in GRANT, saturates.
//
// CONFIGURATION
// - ARB_TIMEOUT_EN defined: when hold counter reaches TIMEOUT_CYCLES-1 with no
//   Done, grant is released on next edge as release event (c); TimeoutErr=1 for
//   exactly that cycle. Done on the expiry cycle wins: normal release, no pulse.
// - ARB_TIMEOUT_EN undefined: no watchdog, grant held indefinitely until Done or
//   Req drop; TimeoutErr tied 0; counter may be omitted.
//
// TESTING
// - Reset: rst=1 2 cycles with Req=4'b1111 -> Grant=0, Sel=0, Busy=0; release
//   rst -> cycle after: Grant=4'b0001, Sel=0.
// - Single: Req=4'b0100 from IDLE -> next cycle Grant=4'b0100, Sel=2; hold 5
//   cycles, Done pulse -> Grant=0, Busy=0 next cycle, Ptr=3.
// - Round robin: Req=4'b1111 constant, Done every 3rd cycle -> Sel sequence
//   0,1,2,3,0 with no idle bubble between grants.
// - Abandon: owner 1 drops Req[1] with Req=4'b1000 pending -> next cycle
//   Grant=4'b1000, Sel=3; Sel stable (no glitch) throughout ownership.
// - Watchdog (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): grant 0, never Done, Req=4'b0011
//   -> 8th grant cycle TimeoutErr=1 one cycle, then Grant=4'b0010; without macro
//   grant 0 held 100 cycles, TimeoutErr=0.
// - Reset mid-grant: owner 2, rst=1 one cycle -> Grant=0, Sel=0, Ptr=0 next edge.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - 4-way round-robin arbiter for a shared memory port; grant held until Done.
// Optional watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] Req,
  input  logic       Done,
  output logic [3:0] Grant,
  output logic [1:0] Sel,
  output logic       Busy,
  output logic       TimeoutErr
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]       state;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] hold_cnt;

  logic             wdog_hit;
  logic             expire;
  logic             release_ev;
  logic [1:0]       arb_ptr;
  logic [3:0]       arb_req;
  logic             found;
  logic [1:0]       win;
  logic [1:0]       idx;

  assign wdog_hit = (hold_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

`ifdef ARB_TIMEOUT_EN
  // Done on the expiry cycle takes precedence, so it is a normal release.
  assign expire = (state == ST_GRANT) && wdog_hit && !Done;
`else
  logic unused_wdog;
  assign unused_wdog = wdog_hit;
  assign expire      = 1'b0;
`endif

  assign release_ev = (state == ST_GRANT) && (Done || !Req[Sel] || expire);

  // On release the owner is masked so it cannot be regranted immediately.
  assign arb_ptr = release_ev ? (Sel + 2'd1) : ptr;
  assign arb_req = release_ev ? (Req & ~Grant) : Req;

  always_comb begin
    found = 1'b0;
    win   = arb_ptr;
    idx   = arb_ptr;
    for (int i = 3; i >= 0; i--) begin
      idx = arb_ptr + 2'(i);
      if (arb_req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      Grant    <= 4'b0000;
      Sel      <= 2'b00;
      ptr      <= 2'b00;
      hold_cnt <= '0;
    end else if (state == ST_IDLE) begin
      if (found) begin
        state    <= ST_GRANT;
        Grant    <= 4'b0001 << win;
        Sel      <= win;
        hold_cnt <= '0;
      end
    end else if (release_ev) begin
      ptr <= arb_ptr;
      if (found) begin
        Grant    <= 4'b0001 << win;
        Sel      <= win;
        hold_cnt <= '0;
      end else begin
        state <= ST_IDLE;
        Grant <= 4'b0000;
      end
    end else if (hold_cnt != {CNT_W{1'b1}}) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  assign Busy       = (state == ST_GRANT);
  assign TimeoutErr = expire;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] Req;
  logic       Done;
  logic [3:0] Grant;
  logic [1:0] Sel;
  logic       Busy;
  logic       TimeoutErr;

  int tests;
  int fails;

  mem_port_arbiter #(
`ifdef ARB_TIMEOUT_EN
    .TIMEOUT_CYCLES(8),
`else
    .TIMEOUT_CYCLES(64),
`endif
    .CNT_W(7)
  ) dut (
    .clk(clk),
    .rst(rst),
    .Req(Req),
    .Done(Done),
    .Grant(Grant),
    .Sel(Sel),
    .Busy(Busy),
    .TimeoutErr(TimeoutErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [3:0] g, input logic [1:0] s, input logic b);
    check({tag, ".grant"}, Grant, g);
    check({tag, ".sel"}, {2'b00, Sel}, {2'b00, s});
    check({tag, ".busy"}, {3'b000, Busy}, {3'b000, b});
  endtask

  logic [1:0] rr_seq [4];

  initial begin
    tests = 0;
    fails = 0;
    rr_seq[0] = 2'd1; rr_seq[1] = 2'd2; rr_seq[2] = 2'd3; rr_seq[3] = 2'd0;

    // Reset held two cycles with everyone requesting
    rst = 1'b1; Req = 4'b1111; Done = 1'b0;
    tick(); tick();
    check_state("reset", 4'b0000, 2'd0, 1'b0);
    check("reset.terr", {3'b000, TimeoutErr}, 4'b0000);
    rst = 1'b0;
    tick();
    check_state("reset_exit", 4'b0001, 2'd0, 1'b1);

    // Round robin, Done every third cycle
    for (int n = 0; n < 4; n++) begin
      tick();
      check("rr.hold", {2'b00, Sel}, (n == 0) ? 4'd0 : {2'b00, rr_seq[n-1]});
      tick();
      Done = 1'b1;
      tick();
      Done = 1'b0;
      check_state("rr.next", 4'b0001 << rr_seq[n], rr_seq[n], 1'b1);
    end

    // All requests drop: owner 0 abandons, back to idle, Sel holds, Ptr=1
    Req = 4'b0000;
    tick();
    check_state("idle", 4'b0000, 2'd0, 1'b0);

    // Single requester 2, held 5 cycles while non-owners toggle
    Req = 4'b0100;
    tick();
    check_state("single", 4'b0100, 2'd2, 1'b1);
    Req = 4'b0111;
    repeat (5) tick();
    check_state("single.hold", 4'b0100, 2'd2, 1'b1);
    Req = 4'b0100; Done = 1'b1;
    tick();
    Done = 1'b0;
    check_state("single.done", 4'b0000, 2'd2, 1'b0);

    // Done while idle is ignored
    Req = 4'b0000; Done = 1'b1;
    tick();
    Done = 1'b0;
    check_state("idle.done", 4'b0000, 2'd2, 1'b0);

    // Ptr is now 3
    Req = 4'b1111;
    tick();
    check_state("ptr3", 4'b1000, 2'd3, 1'b1);

    // Done and Req[3] drop together: one release, Ptr=0
    Req = 4'b0111; Done = 1'b1;
    tick();
    Done = 1'b0;
    check_state("done_drop", 4'b0001, 2'd0, 1'b1);

    // Owner 0 releases to 1
    Req = 4'b0011; Done = 1'b1;
    tick();
    Done = 1'b0;
    check_state("to1", 4'b0010, 2'd1, 1'b1);

    // Abandon: owner 1 drops with 3 pending
    Req = 4'b1010;
    tick();
    check("abandon.stable", {2'b00, Sel}, 4'd1);
    Req = 4'b1000;
    tick();
    check_state("abandon", 4'b1000, 2'd3, 1'b1);

    // Reach owner 2 with Ptr=2
    Req = 4'b0010;
    tick();
    check_state("to1b", 4'b0010, 2'd1, 1'b1);
    Req = 4'b0110; Done = 1'b1;
    tick();
    Done = 1'b0;
    check_state("to2", 4'b0100, 2'd2, 1'b1);

    // Reset mid-grant clears Ptr
    Req = 4'b1111; rst = 1'b1;
    tick();
    check_state("rst_mid", 4'b0000, 2'd0, 1'b0);
    rst = 1'b0;
    tick();
    check_state("rst_mid.ptr0", 4'b0001, 2'd0, 1'b1);

    // Watchdog scenario: grant 0 with Req=0011, never Done
    rst = 1'b1; Req = 4'b0000;
    tick();
    rst = 1'b0; Req = 4'b0011;
    tick();
    check_state("wd.start", 4'b0001, 2'd0, 1'b1);
`ifdef ARB_TIMEOUT_EN
    repeat (6) begin
      check("wd.quiet", {3'b000, TimeoutErr}, 4'b0000);
      tick();
    end
    check("wd.quiet7", {3'b000, TimeoutErr}, 4'b0000);
    tick();
    check("wd.pulse", {3'b000, TimeoutErr}, 4'b0001);
    check("wd.pulse.grant", Grant, 4'b0001);
    tick();
    check("wd.after", {3'b000, TimeoutErr}, 4'b0000);
    check_state("wd.regrant", 4'b0010, 2'd1, 1'b1);
`else
    for (int n = 0; n < 100; n++) begin
      tick();
      check("nowd.grant", Grant, 4'b0001);
      check("nowd.terr", {3'b000, TimeoutErr}, 4'b0000);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
